// File: rtl/pc_fetch_unit.sv
// PC owner and in-order instruction fetch with a small registered FIFO toward decode.
// state | meaning: BOOT = first cycle out of reset, no fetch; RUN = slot free, request asserted; FULL = all slots in use
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_en,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_W  = (CW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc;
    logic [CW-1:0] out_cnt, out_nxt;
    logic [CW-1:0] disc_cnt, disc_nxt;
    logic [CW-1:0] fifo_cnt, fifo_nxt;
    logic [CW:0]   used_nxt;
    logic [PW-1:0] q_rd, q_wr, f_rd, f_wr;
    logic [31:0]   q_pc    [BUF_DEPTH];
    logic [31:0]   f_instr [BUF_DEPTH];
    logic [31:0]   f_pc    [BUF_DEPTH];
    logic          fire, rsp, redirect, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        fire     = imem_req && imem_gnt;
        rsp      = imem_rvalid && (out_cnt != '0);
        redirect = br_en && (state != BOOT);
        push     = rsp && !redirect && (disc_cnt == '0);
        pop      = id_valid && id_ready;
    end

    // Words still to be discarded stay in out_cnt, so they keep holding a slot.
    always_comb begin
        out_nxt = out_cnt;
        if (fire && !rsp) begin
            out_nxt = out_cnt + CW'(1);
        end else if (!fire && rsp) begin
            out_nxt = out_cnt - CW'(1);
        end

        disc_nxt = disc_cnt;
        if (redirect) begin
            disc_nxt = out_nxt;
        end else if (rsp && (disc_cnt != '0)) begin
            disc_nxt = disc_cnt - CW'(1);
        end

        fifo_nxt = fifo_cnt;
        if (redirect) begin
            fifo_nxt = '0;
        end else if (push && !pop) begin
            fifo_nxt = fifo_cnt + CW'(1);
        end else if (pop && !push) begin
            fifo_nxt = fifo_cnt - CW'(1);
        end

        used_nxt = {1'b0, out_nxt} + {1'b0, fifo_nxt};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:      state_nxt = RUN;
            RUN, FULL: state_nxt = (used_nxt < DEPTH_W) ? RUN : FULL;
            default:   state_nxt = BOOT;
        endcase
    end

    always_comb begin
        imem_req  = (state == RUN);
        imem_addr = pc;
        id_valid  = (fifo_cnt != '0);
        id_instr  = id_valid ? f_instr[f_rd] : '0;
        id_pc     = id_valid ? f_pc[f_rd] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            out_cnt  <= '0;
            disc_cnt <= '0;
            fifo_cnt <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            f_rd     <= '0;
            f_wr     <= '0;
        end else begin
            state    <= state_nxt;
            out_cnt  <= out_nxt;
            disc_cnt <= disc_nxt;
            fifo_cnt <= fifo_nxt;

            if (redirect) begin
                pc <= br_target & 32'hFFFF_FFFC;
            end else if (fire) begin
                pc <= pc + 32'd4;
            end

            if (fire) begin
                q_wr <= ptr_inc(q_wr);
            end
            if (rsp) begin
                q_rd <= ptr_inc(q_rd);
            end

            if (redirect) begin
                f_rd <= '0;
                f_wr <= '0;
            end else begin
                if (push) begin
                    f_wr <= ptr_inc(f_wr);
                end
                if (pop) begin
                    f_rd <= ptr_inc(f_rd);
                end
            end
        end
    end

    // Payload storage needs no reset: occupancy counters/pointers gate every read.
    always_ff @(posedge clk) begin
        if (fire) begin
            q_pc[q_wr] <= pc;
        end
        if (push) begin
            f_instr[f_wr] <= imem_rdata;
            f_pc[f_wr]    <= q_pc[q_rd];
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against a queue-based fetch model and a simple memory responder.
module tb_pc_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;

    pc_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .br_en(br_en), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit squash; } fl_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } fe_t;
    typedef struct { logic [31:0] addr; int due; } mr_t;

    fl_t         inflight[$];
    fe_t         fifo_m[$];
    mr_t         mem_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];
    bit          m_booted = 1'b0;
    logic [31:0] m_pc = RPC;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          gnt_pct = 0, rv_pct = 0, rdy_pct = 0, br_pct = 0, lat_max = 0;
    bit          br_once = 1'b0;
    logic [31:0] br_once_tgt = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    function automatic bit m_req();
        return m_booted && ((inflight.size() + fifo_m.size()) < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic chk_pop(input string name, input int idx, input logic [31:0] exp);
        if (idx < pop_log.size()) begin
            chk(name, pop_log[idx], exp);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: got no pop (only %0d) expected %08h", name, pop_log.size(), exp);
        end
    endtask

    task automatic chk_gnt(input string name, input int idx, input logic [31:0] exp);
        if (idx < gnt_log.size()) begin
            chk(name, gnt_log[idx], exp);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: got no grant (only %0d) expected %08h", name, gnt_log.size(), exp);
        end
    endtask

    task automatic set_knobs(input int g, input int rv, input int rdy, input int br, input int lat);
        gnt_pct = g; rv_pct = rv; rdy_pct = rdy; br_pct = br; lat_max = lat;
    endtask

    task automatic drive_inputs();
        imem_gnt = (int'($urandom_range(0, 99)) < gnt_pct);
        id_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && int'($urandom_range(0, 99)) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        if (br_once) begin
            br_en     = 1'b1;
            br_target = br_once_tgt;
            br_once   = 1'b0;
        end else begin
            br_en     = (int'($urandom_range(0, 99)) < br_pct);
            br_target = $urandom;
        end
    endtask

    task automatic compare_all();
        chk("imem_req", 32'(imem_req), 32'(m_req()));
        chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", 32'(id_valid), 32'(fifo_m.size() != 0));
        if (fifo_m.size() != 0) begin
            chk("id_instr", id_instr, fifo_m[0].instr);
            chk("id_pc", id_pc, fifo_m[0].pc);
        end
        if (imem_req && imem_gnt) gnt_log.push_back(imem_addr);
        if (id_valid && id_ready) pop_log.push_back(id_pc);
    endtask

    task automatic model_update();
        bit          fire;
        bit          rsp;
        logic [31:0] old_pc;
        fl_t         e;
        cyc++;
        if (!m_booted) begin
            m_booted = 1'b1;
            return;
        end
        fire   = m_req() && imem_gnt;
        rsp    = imem_rvalid && (inflight.size() > 0);
        old_pc = m_pc;
        if (imem_rvalid) void'(mem_q.pop_front());
        if (fire) mem_q.push_back('{addr: old_pc, due: cyc + int'($urandom_range(0, lat_max))});
        if (br_en) begin
            fifo_m.delete();
            if (rsp) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].squash = 1'b1;
            if (fire) inflight.push_back('{pc: old_pc, squash: 1'b1});
            m_pc = br_target & 32'hFFFF_FFFC;
        end else begin
            if (id_ready && fifo_m.size() > 0) void'(fifo_m.pop_front());
            if (rsp) begin
                e = inflight.pop_front();
                if (!e.squash) fifo_m.push_back('{instr: imem_rdata, pc: e.pc});
            end
            if (fire) begin
                inflight.push_back('{pc: old_pc, squash: 1'b0});
                m_pc = old_pc + 32'd4;
            end
        end
    endtask

    // Entered and left at a negedge, so outputs are settled for checks between steps.
    task automatic step();
        drive_inputs();
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain();
        set_knobs(0, 100, 100, 0, 0);
        run(8);
    endtask

    initial begin
        int p0;
        int g0;

        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RPC);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        rst_n = 1'b1;

        // streaming from reset
        set_knobs(100, 100, 100, 0, 0);
        run(14);
        chk_gnt("t1_gnt0", 0, 32'h0);
        chk_gnt("t1_gnt1", 1, 32'h4);
        chk_gnt("t1_gnt2", 2, 32'h8);
        chk_pop("t1_pop0", 0, 32'h0);
        chk_pop("t1_pop1", 1, 32'h4);
        chk_pop("t1_pop2", 2, 32'h8);

        // decode stalled: fetch stops after BUF_DEPTH words
        set_knobs(100, 100, 0, 0, 0);
        run(10);
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_valid_full", 32'(id_valid), 32'd1);
        g0 = gnt_log.size();
        run(4);
        chk("t2_no_gnt", 32'(gnt_log.size() - g0), 32'd0);
        rdy_pct = 100;
        run(6);
        chk("t2_resume", 32'(gnt_log.size() > g0), 32'd1);

        // grant withheld
        drain();
        br_once = 1'b1; br_once_tgt = 32'h10;
        set_knobs(0, 100, 100, 0, 0);
        run(1);
        chk("t3_req_a", 32'(imem_req), 32'd1);
        chk("t3_addr_a", imem_addr, 32'h10);
        run(1);
        chk("t3_addr_b", imem_addr, 32'h10);
        run(1);
        chk("t3_req_c", 32'(imem_req), 32'd1);
        chk("t3_addr_c", imem_addr, 32'h10);
        gnt_pct = 100;
        run(1);
        chk("t3_addr_adv", imem_addr, 32'h14);

        // redirect with two words outstanding
        drain();
        set_knobs(100, 0, 100, 0, 0);
        run(4);
        chk("t4_req_full", 32'(imem_req), 32'd0);
        br_once = 1'b1; br_once_tgt = 32'h100;
        run(1);
        chk("t4_valid_flush", 32'(id_valid), 32'd0);
        chk("t4_req_still_full", 32'(imem_req), 32'd0);
        chk("t4_addr", imem_addr, 32'h100);
        p0 = pop_log.size();
        set_knobs(100, 100, 100, 0, 0);
        run(12);
        chk_pop("t4_pop0", p0, 32'h100);
        chk_pop("t4_pop1", p0 + 1, 32'h104);

        // redirect coinciding with rvalid and a granted request
        drain();
        set_knobs(100, 0, 100, 0, 0);
        run(1);
        br_once = 1'b1; br_once_tgt = 32'h200;
        set_knobs(100, 100, 100, 0, 0);
        run(1);
        chk("t5_req", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, 32'h200);
        chk("t5_valid", 32'(id_valid), 32'd0);
        p0 = pop_log.size();
        run(10);
        chk_pop("t5_pop0", p0, 32'h200);

        // PC wrap
        drain();
        br_once = 1'b1; br_once_tgt = 32'hFFFF_FFFE;
        set_knobs(0, 100, 100, 0, 0);
        run(1);
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        gnt_pct = 100;
        run(1);
        chk("t6_addr_wrap", imem_addr, 32'h0);

        // reset mid-stream with a full FIFO
        set_knobs(100, 100, 0, 0, 0);
        run(8);
        chk("t7_valid_pre", 32'(id_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_req_rst", 32'(imem_req), 32'd0);
        chk("t7_valid_rst", 32'(id_valid), 32'd0);
        inflight.delete(); fifo_m.delete(); mem_q.delete();
        m_booted = 1'b0; m_pc = RPC;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0; br_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t7_addr_rst", imem_addr, RPC);
        rst_n = 1'b1;
        br_once = 1'b1; br_once_tgt = 32'h300;
        set_knobs(100, 100, 100, 0, 0);
        p0 = pop_log.size();
        run(12);
        chk_pop("t7_pop0", p0, RPC);
        chk_pop("t7_pop1", p0 + 1, RPC + 32'd4);

        // random traffic with redirects
        for (int blk = 0; blk < 12; blk++) begin
            set_knobs(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                      int'($urandom_range(20, 100)), int'($urandom_range(0, 8)),
                      int'($urandom_range(0, 3)));
            run(60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
